// File: rtl/raster_window_counter.sv
// rtl/raster_window_counter.sv - raster-order row/column walker with Sobel window qualifiers
//
// Purpose:
//   Walks a runtime-sized image in raster order (column fastest) and presents
//   the current pixel coordinates together with per-pixel qualifiers for the
//   line buffers / Sobel kernel downstream of the pixel loader.
//
// Ports:
//   CLK         rising-edge clock
//   Reset       asynchronous active-high reset
//   Start       begin a frame (accepted only while isReady=1)
//   Clear       synchronous abort to IDLE, beats Start and Enable
//   Enable      consume the current position / stall
//   Last_Col    last column index, latched on an accepted Start
//   Last_Row    last row index, latched on an accepted Start
//   Out_Row     current row
//   Out_Column  current column
//   Out_Valid   current position consumed this cycle
//   Win_Valid   consumed pixel completes a full WIN x WIN window
//   Line_End    consumed pixel is the last of its row
//   Frame_Last  consumed pixel is the last of the frame
//   isReady     block can accept Start (IDLE or DONE)
//   isEnd       one-shot frame finished (DONE)

module raster_window_counter #(
   parameter int NumOfBit   = 8,
   parameter int WIN        = 3,
   parameter int CONTINUOUS = 0
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Clear,
   input  logic                Enable,
   input  logic [NumOfBit-1:0] Last_Col,
   input  logic [NumOfBit-1:0] Last_Row,
   output logic [NumOfBit-1:0] Out_Row,
   output logic [NumOfBit-1:0] Out_Column,
   output logic                Out_Valid,
   output logic                Win_Valid,
   output logic                Line_End,
   output logic                Frame_Last,
   output logic                isReady,
   output logic                isEnd
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // First row/column index at which a full kernel window is available.
   localparam logic [NumOfBit-1:0] WIN_FIRST = NumOfBit'(WIN - 1);
   localparam logic [NumOfBit-1:0] ONE       = NumOfBit'(1);

   logic [1:0]          state_q, state_d;
   logic [NumOfBit-1:0] row_q, row_d;
   logic [NumOfBit-1:0] col_q, col_d;
   logic [NumOfBit-1:0] lc_q, lc_d;
   logic [NumOfBit-1:0] lr_q, lr_d;

   logic at_col_end;
   logic at_row_end;

   assign at_col_end = (col_q == lc_q);
   assign at_row_end = (row_q == lr_q);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      lc_d    = lc_q;
      lr_d    = lr_q;
      if (Clear) begin
         // Abort keeps the latched sizes; only position and state are reset.
         state_d = ST_IDLE;
         row_d   = '0;
         col_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  lc_d    = Last_Col;
                  lr_d    = Last_Row;
                  row_d   = '0;
                  col_d   = '0;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (Enable) begin
                  if (!at_col_end) begin
                     col_d = col_q + ONE;
                  end else if (!at_row_end) begin
                     col_d = '0;
                     row_d = row_q + ONE;
                  end else if (CONTINUOUS != 0) begin
                     row_d = '0;
                     col_d = '0;
                  end else begin
                     // One-shot: hold the final position for inspection.
                     state_d = ST_DONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         lc_q    <= '0;
         lr_q    <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         lc_q    <= lc_d;
         lr_q    <= lr_d;
      end
   end

   assign Out_Row    = row_q;
   assign Out_Column = col_q;
   assign Out_Valid  = (state_q == ST_SCAN) & Enable;
   assign Line_End   = Out_Valid & at_col_end;
   assign Frame_Last = Line_End & at_row_end;
   assign Win_Valid  = Out_Valid & (row_q >= WIN_FIRST) & (col_q >= WIN_FIRST);
   assign isReady    = (state_q == ST_IDLE) | (state_q == ST_DONE);
   assign isEnd      = (state_q == ST_DONE);

endmodule

// File: tb/tb_raster_window_counter.sv
// tb/tb_raster_window_counter.sv - scoreboard bench for raster_window_counter

module tb_raster_window_counter;

   typedef struct packed {
      logic [7:0] row;
      logic [7:0] col;
      logic       le;
      logic       fl;
      logic       wv;
   } pix_t;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;

   // One-shot instance
   logic       Start = 1'b0, Clear = 1'b0, Enable = 1'b0;
   logic [7:0] Last_Col = 8'd0, Last_Row = 8'd0;
   logic [7:0] Out_Row, Out_Column;
   logic       Out_Valid, Win_Valid, Line_End, Frame_Last, isReady, isEnd;

   // Continuous instance
   logic       Start_c = 1'b0, Clear_c = 1'b0, Enable_c = 1'b0;
   logic [7:0] Last_Col_c = 8'd0, Last_Row_c = 8'd0;
   logic [7:0] Out_Row_c, Out_Column_c;
   logic       Out_Valid_c, Win_Valid_c, Line_End_c, Frame_Last_c, isReady_c, isEnd_c;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   win_cnt   = 0;
   pix_t sb[$];
   pix_t sbc[$];

   always #5 CLK = ~CLK;

   raster_window_counter #(.NumOfBit(8), .WIN(3), .CONTINUOUS(0)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Clear(Clear), .Enable(Enable),
      .Last_Col(Last_Col), .Last_Row(Last_Row),
      .Out_Row(Out_Row), .Out_Column(Out_Column), .Out_Valid(Out_Valid),
      .Win_Valid(Win_Valid), .Line_End(Line_End), .Frame_Last(Frame_Last),
      .isReady(isReady), .isEnd(isEnd)
   );

   raster_window_counter #(.NumOfBit(8), .WIN(3), .CONTINUOUS(1)) dut_c (
      .CLK(CLK), .Reset(Reset), .Start(Start_c), .Clear(Clear_c), .Enable(Enable_c),
      .Last_Col(Last_Col_c), .Last_Row(Last_Row_c),
      .Out_Row(Out_Row_c), .Out_Column(Out_Column_c), .Out_Valid(Out_Valid_c),
      .Win_Valid(Win_Valid_c), .Line_End(Line_End_c), .Frame_Last(Frame_Last_c),
      .isReady(isReady_c), .isEnd(isEnd_c)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic pix_t mk(input int r, input int c, input int lc, input int lr);
      pix_t p;
      p.row = 8'(r);
      p.col = 8'(c);
      p.le  = (c == lc);
      p.fl  = (c == lc) && (r == lr);
      p.wv  = (r >= 2) && (c >= 2);
      return p;
   endfunction

   // Monitor: one-shot instance
   always @(negedge CLK) begin
      if (!Reset) begin
         if (Out_Valid) begin
            if (Win_Valid) win_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_valid", {Out_Row, Out_Column}, 32'hFFFF_FFFF);
            end else begin
               pix_t e;
               e = sb.pop_front();
               check("pix_row", Out_Row, e.row);
               check("pix_col", Out_Column, e.col);
               check("pix_quals", {Line_End, Frame_Last, Win_Valid}, {e.le, e.fl, e.wv});
            end
         end else begin
            check("stall_quals", {Line_End, Frame_Last, Win_Valid}, 0);
         end
      end
   end

   // Monitor: continuous instance
   always @(negedge CLK) begin
      if (!Reset && Out_Valid_c) begin
         if (sbc.size() == 0) begin
            check("c_unexpected_valid", {Out_Row_c, Out_Column_c}, 32'hFFFF_FFFF);
         end else begin
            pix_t e;
            e = sbc.pop_front();
            check("c_pix_row", Out_Row_c, e.row);
            check("c_pix_col", Out_Column_c, e.col);
            check("c_pix_quals", {Line_End_c, Frame_Last_c, Win_Valid_c}, {e.le, e.fl, e.wv});
         end
      end
   end

   task automatic drain(input string name, input bit cont);
      for (int n = 0; n < 30; n++) begin
         if ((cont ? sbc.size() : sb.size()) == 0) break;
         @(negedge CLK);
         #1;
      end
      check({"drain_", name}, cont ? sbc.size() : sb.size(), 0);
      sb.delete();
      sbc.delete();
   endtask

   task automatic run_frame(input string name, input int lc, input int lr, input bit toggle);
      int n;
      int cycles;
      n = (lc + 1) * (lr + 1);
      cycles = toggle ? 2 * n : n;
      tick();
      Start = 1'b1; Last_Col = 8'(lc); Last_Row = 8'(lr); Enable = 1'b0;
      for (int r = 0; r <= lr; r++)
         for (int c = 0; c <= lc; c++)
            sb.push_back(mk(r, c, lc, lr));
      tick();
      // Sizes change while scanning and must be ignored.
      Start = 1'b0; Last_Col = 8'hAA; Last_Row = 8'h55; Enable = 1'b1;
      @(negedge CLK);
      check({name, "_ready_low"}, {isReady, isEnd}, 2'b00);
      for (int i = 1; i < cycles; i++) begin
         tick();
         Enable = toggle ? (i % 2 == 0) : 1'b1;
      end
      tick();
      Enable = 1'b0;
      @(negedge CLK);
      check({name, "_done"}, {isEnd, isReady}, 2'b11);
      check({name, "_hold_pos"}, {Out_Row, Out_Column}, {8'(lr), 8'(lc)});
      drain(name, 1'b0);
   endtask

   task automatic start_partial(input int npix);
      tick();
      Start = 1'b1; Last_Col = 8'd3; Last_Row = 8'd2; Enable = 1'b0;
      for (int i = 0; i < npix; i++) sb.push_back(mk(i / 4, i % 4, 3, 2));
      tick();
      Start = 1'b0; Enable = 1'b1;
      for (int i = 1; i < 6; i++) tick();
      tick();
      check("at_1_2", {Out_Row, Out_Column}, {8'd1, 8'd2});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #20 Reset = 1'b0;
      @(negedge CLK);
      check("rst_pos", {Out_Row, Out_Column}, 16'h0000);
      check("rst_flags", {isReady, isEnd, Out_Valid, Win_Valid, Line_End, Frame_Last}, 6'b100000);
      check("rst_c_flags", {isReady_c, isEnd_c, Out_Valid_c}, 3'b100);

      run_frame("f32", 3, 2, 1'b0);
      run_frame("f32_tog", 3, 2, 1'b1);

      win_cnt = 0;
      run_frame("win43", 4, 3, 1'b0);
      check("win43_count", win_cnt, 6);
      win_cnt = 0;
      run_frame("win12", 1, 2, 1'b0);
      check("win12_count", win_cnt, 0);

      // Async reset mid-frame, asserted between clock edges.
      start_partial(6);
      #2 Reset = 1'b1;
      #1;
      check("arst_pos", {Out_Row, Out_Column}, 16'h0000);
      check("arst_flags", {isReady, isEnd, Out_Valid, Win_Valid, Line_End, Frame_Last}, 6'b100000);
      tick();
      Reset = 1'b0; Enable = 1'b0;
      drain("arst", 1'b0);

      // Clear beats simultaneous Start and Enable.
      start_partial(7);
      Clear = 1'b1; Start = 1'b1;
      tick();
      Clear = 1'b0; Start = 1'b0;
      @(negedge CLK);
      check("clr_state", {isReady, isEnd, Out_Valid}, 3'b100);
      check("clr_pos", {Out_Row, Out_Column}, 16'h0000);
      tick();
      Enable = 1'b0;
      drain("clr", 1'b0);

      run_frame("one_px", 0, 0, 1'b0);
      run_frame("relatch", 2, 0, 1'b0);

      // Continuous mode: 2x2 frame repeated, Start pulses in SCAN ignored.
      tick();
      Start_c = 1'b1; Last_Col_c = 8'd1; Last_Row_c = 8'd1;
      for (int i = 0; i < 10; i++) sbc.push_back(mk((i / 2) % 2, i % 2, 1, 1));
      tick();
      Start_c = 1'b0; Enable_c = 1'b1;
      for (int i = 1; i < 10; i++) begin
         tick();
         Start_c    = (i == 3 || i == 7);
         Last_Col_c = (i == 3 || i == 7) ? 8'd3 : 8'd1;
         @(negedge CLK);
         check("c_isend", {isEnd_c, isReady_c}, 2'b00);
      end
      tick();
      Enable_c = 1'b0; Start_c = 1'b0; Last_Col_c = 8'd1;
      @(negedge CLK);
      check("c_still_scan", {isEnd_c, isReady_c}, 2'b00);
      check("c_pos_wrapped", {Out_Row_c, Out_Column_c}, {8'd1, 8'd0});
      tick();
      Clear_c = 1'b1;
      tick();
      Clear_c = 1'b0;
      @(negedge CLK);
      check("c_clear", {isReady_c, Out_Row_c, Out_Column_c}, {1'b1, 16'h0000});
      drain("cont", 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/raster_window_counter.md
Name: raster_window_counter

Overview:
- Parametrised successor to the Loader row/column counter. Walks a runtime-sized image in raster order (column fastest) and emits the current pixel coordinates.
- Adds per-pixel qualifiers for the Sobel window datapath: pixel valid, line end, frame last, and kernel-window valid.
- Supports start/clear control, Enable stalls, and one-shot or continuous (frame-repeating) mode.
- Sits between the pixel loader and the line buffers / Sobel kernel.

Parameters:
NumOfBit, 8, width of the row/column counters and the size inputs
WIN, 3, kernel size; the window is valid once row >= WIN-1 and col >= WIN-1
CONTINUOUS, 0, 0 = stop after one frame; 1 = wrap to (0,0) and keep scanning

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  begin a frame; sampled only when isReady=1
Clear  in  1  synchronous abort to IDLE; has priority over Start and Enable
Enable  in  1  advance/stall; position is consumed on a cycle with Enable=1 in SCAN
Last_Col  in  NumOfBit  last column index (width-1), latched on accepted Start
Last_Row  in  NumOfBit  last row index (height-1), latched on accepted Start
Out_Row  out  NumOfBit  current row
Out_Column  out  NumOfBit  current column
Out_Valid  out  1  current position consumed this cycle
Win_Valid  out  1  consumed pixel completes a full WINxWIN window
Line_End  out  1  consumed pixel is the last in its row
Frame_Last  out  1  consumed pixel is (Last_Row, Last_Col)
isReady  out  1  block can accept Start
isEnd  out  1  one-shot frame finished (level)

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high.
- Reset values: state=IDLE, Out_Row=0, Out_Column=0, latched sizes=0, isReady=1, isEnd=0. Out_Valid, Win_Valid, Line_End and Frame_Last are all 0.
- Asserting Reset mid-frame forces these values immediately, without waiting for a clock edge.
- States: IDLE, SCAN, DONE.
  - isReady = (state==IDLE or DONE), combinational from state.
  - isEnd = (state==DONE).
- IDLE/DONE with Start=1 and Clear=0:
  - Latch Last_Col/Last_Row.
  - Set row=col=0 and enter SCAN.
  - isReady and isEnd go low the following cycle.
- Start is ignored while in SCAN. Size inputs are ignored except on an accepted Start.
- SCAN, Enable=1: Out_Valid=1 (combinational = SCAN & Enable), and the counter advances at the clock edge.
  - col<LC: col+1.
  - col==LC and row<LR: col=0, row+1.
  - col==LC and row==LR, CONTINUOUS=0: go to DONE; row/col hold at the final position.
  - col==LC and row==LR, CONTINUOUS=1: row=col=0, stay in SCAN, isEnd stays 0.
- SCAN, Enable=0: counters hold; all qualifiers are 0.
- Qualifiers are combinational, gated by Out_Valid, and use the latched sizes:
  - Line_End = Out_Valid & col==LC.
  - Frame_Last = Line_End & row==LR.
  - Win_Valid = Out_Valid & row>=WIN-1 & col>=WIN-1.
- Latency: coordinates are registered. The first valid pixel (0,0) is presented one cycle after Start is accepted.
- Clear=1 in any state: next cycle state=IDLE and row=col=0. Latched sizes are retained. Clear has priority over a simultaneous Start or Enable.
- Degenerate sizes:
  - LC=0: every consumed pixel has Line_End=1.
  - LC=LR=0: a one-pixel frame, so Frame_Last=1 on the first consumed cycle.
  - LC<WIN-1 or LR<WIN-1: Win_Valid is never asserted.
- Arithmetic: all compares are unsigned NumOfBit wide. The counters never exceed the latched limits, so they cannot overflow.
- DONE persists until Start, Clear or Reset.

Test Plan:
- Reset=1 for 20ns, Start with LC=3, LR=2, Enable=1:
  - 12 consecutive Out_Valid cycles in order (0,0)..(2,3).
  - Line_End at col 3.
  - Frame_Last at (2,3), then isEnd=1 and isReady=1; coordinates hold (2,3).
- Same frame, Enable toggling 1,0 each cycle: 12 valid pulses over 24 cycles, no position skipped or repeated, qualifiers 0 on stall cycles.
- WIN=3, LC=4, LR=3: Win_Valid exactly at rows 2-3 × cols 2-4 (6 pulses). A separate LC=1 run gives zero Win_Valid.
- CONTINUOUS=1, LC=1, LR=1:
  - Sequence (0,0),(0,1),(1,0),(1,1),(0,0)... with Frame_Last every 4th valid cycle.
  - isEnd never 1.
  - Start pulses during SCAN are ignored.
- Mid-frame at (1,2):
  - Async Reset pulse: outputs return to reset values before the next edge.
  - Separately, Clear=1 with Start=1: next cycle IDLE, (0,0), isReady=1.
- LC=0, LR=0: Start gives one valid cycle with Line_End=Frame_Last=1, then DONE. A new Start with LC=2 re-latches the size and scans 3 pixels.
